// File: rtl/cvt_pkt_buffer.sv
// Convertible single-packet buffer: fill, in-place processing through port A, drain.
// Circular SRAM window with wrap, oversize drop with saturating counter, bypass mode.
module cvt_pkt_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH/8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic [CTRL_WIDTH-1:0]            in_ctrl,
    input  logic                             in_wr,
    output logic                             in_rdy,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    input  logic [ADDR_WIDTH-1:0]            proc_addr,
    input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] proc_wdata,
    input  logic                             proc_we,
    output logic [DATA_WIDTH+CTRL_WIDTH-1:0] proc_rdata,
    input  logic                             proc_done,
    input  logic                             bypass,
    output logic [ADDR_WIDTH-1:0]            first_addr,
    output logic [ADDR_WIDTH-1:0]            last_addr,
    output logic                             pkt_ready,
    output logic [1:0]                       state,
    output logic [15:0]                      drop_count
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int WW    = DATA_WIDTH + CTRL_WIDTH;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PROC  = 2'd1,
        DRAIN = 2'd2,
        DROP  = 2'd3
    } state_t;

    logic [WW-1:0]         mem [DEPTH];
    state_t                st;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  seen_body;
    logic                  drop_eop;
    logic                  rd_pending;
    logic                  q_valid;
    logic [WW-1:0]         q;

    logic accept, hdr, eop, full, consume, issue;

    assign accept  = in_wr & in_rdy;
    assign hdr     = |in_ctrl;
    assign eop     = hdr & seen_body;
    assign full    = &cnt;
    assign consume = q_valid & out_rdy;
    assign issue   = rd_pending & (~q_valid | consume);
    assign state   = st;

    // Port A writes only in PROC, stream writes only in FILL: never both in one cycle.
    always_ff @(posedge clk) begin
        if (st == PROC && proc_we)
            mem[proc_addr] <= proc_wdata;
        else if (st == FILL && accept && !full)
            mem[wr_ptr] <= {in_ctrl, in_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st         <= FILL;
            in_rdy     <= 1'b0;
            out_wr     <= 1'b0;
            out_data   <= '0;
            out_ctrl   <= '0;
            proc_rdata <= '0;
            first_addr <= '0;
            last_addr  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            pkt_ready  <= 1'b0;
            drop_count <= '0;
            seen_body  <= 1'b0;
            drop_eop   <= 1'b0;
            rd_pending <= 1'b0;
            q_valid    <= 1'b0;
            q          <= '0;
        end else begin
            proc_rdata <= mem[proc_addr];
            out_wr     <= 1'b0;
            case (st)
                FILL: begin
                    in_rdy <= 1'b1;
                    if (accept) begin
                        seen_body <= seen_body | ~hdr;
                        if (full) begin
                            st       <= DROP;
                            drop_eop <= eop;
                            in_rdy   <= ~eop;
                            if (drop_count != 16'hFFFF)
                                drop_count <= drop_count + 16'd1;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                            cnt    <= cnt + 1'b1;
                            if (eop) begin
                                last_addr <= wr_ptr;
                                in_rdy    <= 1'b0;
                                cnt       <= '0;
                                seen_body <= 1'b0;
                                if (bypass) begin
                                    st         <= DRAIN;
                                    rd_pending <= 1'b1;
                                    rd_ptr     <= first_addr;
                                end else begin
                                    st        <= PROC;
                                    pkt_ready <= 1'b1;
                                end
                            end
                        end
                    end
                end
                PROC: begin
                    if (proc_done) begin
                        st         <= DRAIN;
                        pkt_ready  <= 1'b0;
                        rd_pending <= 1'b1;
                        rd_ptr     <= first_addr;
                    end
                end
                DRAIN: begin
                    if (consume) begin
                        out_wr               <= 1'b1;
                        {out_ctrl, out_data} <= q;
                    end
                    if (issue) begin
                        q       <= mem[rd_ptr];
                        q_valid <= 1'b1;
                        rd_ptr  <= rd_ptr + 1'b1;
                        if (rd_ptr == last_addr)
                            rd_pending <= 1'b0;
                    end else if (consume) begin
                        q_valid <= 1'b0;
                    end
                    // Exit one cycle after the last out_wr so in_rdy follows it.
                    if (!q_valid && !rd_pending) begin
                        st         <= FILL;
                        first_addr <= last_addr + 1'b1;
                        wr_ptr     <= last_addr + 1'b1;
                        in_rdy     <= 1'b1;
                    end
                end
                DROP: begin
                    in_rdy <= 1'b1;
                    if (drop_eop || (accept && eop)) begin
                        st        <= FILL;
                        wr_ptr    <= first_addr;
                        cnt       <= '0;
                        seen_body <= 1'b0;
                        drop_eop  <= 1'b0;
                    end else if (accept) begin
                        seen_body <= seen_body | ~hdr;
                    end
                end
                default: st <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_cvt_pkt_buffer.sv
// Self-checking bench for cvt_pkt_buffer at ADDR_WIDTH=4 (DEPTH=16).
// Packet table plus hand sequences for drop and reset; output words via scoreboard queue.
module tb_cvt_pkt_buffer;
    localparam int DW = 64;
    localparam int CW = 8;
    localparam int AW = 4;
    localparam int WW = DW + CW;
    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_PROC  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          in_wr = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_wr;
    logic          out_rdy = 1'b1;
    logic [AW-1:0] proc_addr = '0;
    logic [WW-1:0] proc_wdata = '0;
    logic          proc_we = 1'b0;
    logic [WW-1:0] proc_rdata;
    logic          proc_done = 1'b0;
    logic          bypass = 1'b0;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic          pkt_ready;
    logic [1:0]    state;
    logic [15:0]   drop_count;

    always #5 clk = ~clk;

    cvt_pkt_buffer #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_we(proc_we),
        .proc_rdata(proc_rdata), .proc_done(proc_done), .bypass(bypass),
        .first_addr(first_addr), .last_addr(last_addr), .pkt_ready(pkt_ready),
        .state(state), .drop_count(drop_count)
    );

    int total = 0;
    int bad = 0;
    int n_out = 0;
    logic [WW-1:0] exp_q[$];
    logic tog_en = 1'b0;
    int tog_i = 0;
    logic [4:0] pat = 5'b11001;
    logic [WW-1:0] last_out = '0;

    task automatic chk(input string nm, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_wr) begin
            n_out++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out got=%0h exp=none", {out_ctrl, out_data});
            end else begin
                chk("out_word", {out_ctrl, out_data}, exp_q.pop_front());
            end
        end else if (tog_en) begin
            chk("out_hold", {out_ctrl, out_data}, last_out);
        end
        last_out = {out_ctrl, out_data};
        if (tog_en) begin
            out_rdy = pat[tog_i % 5];
            tog_i++;
        end else begin
            out_rdy = 1'b1;
        end
    end

    task automatic put(input logic [CW-1:0] c, input logic [DW-1:0] d);
        int k = 0;
        while (!in_rdy && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!in_rdy) begin
            total++;
            bad++;
            $display("FAIL in_rdy_timeout got=0 exp=1");
        end
        in_wr = 1'b1;
        in_ctrl = c;
        in_data = d;
        @(negedge clk);
        in_wr = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [DW-1:0] base, input bit push);
        logic [CW-1:0] c;
        for (int i = 0; i < n; i++) begin
            c = (i == 0) ? 8'hFF : (i == n - 1) ? 8'h01 : 8'h00;
            if (push) exp_q.push_back({c, base + 64'(i)});
            put(c, base + 64'(i));
        end
    endtask

    task automatic wait_st(input logic [1:0] s, input int max);
        int k = 0;
        while (state !== s && k < max) begin
            @(negedge clk);
            k++;
        end
        chk("wait_state", 72'(state), 72'(s));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_wr = 1'b0;
        proc_we = 1'b0;
        proc_done = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("rst_state", 72'(state), 72'(S_FILL));
        chk("rst_in_rdy", 72'(in_rdy), 72'd0);
        chk("rst_out_wr", 72'(out_wr), 72'd0);
        chk("rst_out", {out_ctrl, out_data}, 72'd0);
        chk("rst_rdata", proc_rdata, 72'd0);
        chk("rst_first", 72'(first_addr), 72'd0);
        chk("rst_last", 72'(last_addr), 72'd0);
        chk("rst_pkt_ready", 72'(pkt_ready), 72'd0);
        chk("rst_drop_count", 72'(drop_count), 72'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_rdy_rel", 72'(in_rdy), 72'd1);
    endtask

    task automatic drain_done(input logic [AW-1:0] nx, input int n, input int n0);
        wait_st(S_FILL, 300);
        chk("fill_in_rdy", 72'(in_rdy), 72'd1);
        chk("next_first", 72'(first_addr), 72'(nx));
        chk("q_empty", 72'(exp_q.size()), 72'd0);
        chk("out_count", 72'(n_out - n0), 72'(n));
    endtask

    task automatic pulse_done();
        proc_done = 1'b1;
        @(negedge clk);
        proc_done = 1'b0;
        proc_we = 1'b0;
        chk("done_state", 72'(state), 72'(S_DRAIN));
        chk("done_no_out", 72'(out_wr), 72'd0);
        chk("done_pkt_ready", 72'(pkt_ready), 72'd0);
    endtask

    typedef struct {
        bit rst;
        int n;
        bit byp;
        int wr;
        bit tog;
        logic [AW-1:0] f;
        logic [AW-1:0] l;
        logic [AW-1:0] nx;
    } rec_t;

    rec_t tbl[6];

    initial begin
        #800000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        int k;
        logic [DW-1:0] base;
        tbl[0] = '{1'b1, 6,  1'b0, 1, 1'b0, 4'd0,  4'd5,  4'd6};
        tbl[1] = '{1'b1, 12, 1'b0, 0, 1'b0, 4'd0,  4'd11, 4'd12};
        tbl[2] = '{1'b0, 7,  1'b0, 0, 1'b0, 4'd12, 4'd2,  4'd3};
        tbl[3] = '{1'b0, 4,  1'b1, 0, 1'b1, 4'd3,  4'd6,  4'd7};
        tbl[4] = '{1'b0, 15, 1'b0, 2, 1'b0, 4'd7,  4'd5,  4'd6};
        tbl[5] = '{1'b0, 3,  1'b1, 0, 1'b0, 4'd6,  4'd8,  4'd9};

        for (int r = 0; r < 6; r++) begin
            if (tbl[r].rst) do_reset();
            bypass = tbl[r].byp;
            tog_en = tbl[r].tog;
            base = 64'h1000 * 64'(r + 1);
            n0 = n_out;
            send_pkt(tbl[r].n, base, 1'b1);
            chk("eop_state", 72'(state), tbl[r].byp ? 72'(S_DRAIN) : 72'(S_PROC));
            chk("eop_in_rdy", 72'(in_rdy), 72'd0);
            chk("eop_first", 72'(first_addr), 72'(tbl[r].f));
            chk("eop_last", 72'(last_addr), 72'(tbl[r].l));
            if (!tbl[r].byp) begin
                chk("pkt_ready", 72'(pkt_ready), 72'd1);
                if (tbl[r].wr == 1) begin
                    proc_addr = tbl[r].f + 4'd3;
                    proc_wdata = 72'hDEAD;
                    proc_we = 1'b1;
                    @(negedge clk);
                    proc_we = 1'b0;
                    @(negedge clk);
                    chk("proc_readback", proc_rdata, 72'hDEAD);
                    exp_q[3] = 72'hDEAD;
                end
                if (tbl[r].wr == 2) begin
                    proc_addr = tbl[r].f + 4'd1;
                    proc_wdata = 72'hBEEF;
                    proc_we = 1'b1;
                    exp_q[1] = 72'hBEEF;
                end
                pulse_done();
            end
            drain_done(tbl[r].nx, tbl[r].n, n0);
            bypass = 1'b0;
            tog_en = 1'b0;
        end

        send_pkt(16, 64'h7000, 1'b0);
        chk("drop16_state", 72'(state), 72'(S_DROP));
        chk("drop16_in_rdy", 72'(in_rdy), 72'd0);
        @(negedge clk);
        chk("drop16_fill", 72'(state), 72'(S_FILL));
        chk("drop16_count", 72'(drop_count), 72'd1);
        chk("drop16_first", 72'(first_addr), 72'd9);
        send_pkt(20, 64'h8000, 1'b0);
        chk("drop20_fill", 72'(state), 72'(S_FILL));
        chk("drop20_count", 72'(drop_count), 72'd2);
        n0 = n_out;
        send_pkt(3, 64'h9000, 1'b1);
        chk("post_drop_state", 72'(state), 72'(S_PROC));
        chk("post_drop_first", 72'(first_addr), 72'd9);
        chk("post_drop_last", 72'(last_addr), 72'd11);
        pulse_done();
        drain_done(4'd12, 3, n0);

        n0 = n_out;
        send_pkt(5, 64'hA000, 1'b1);
        chk("mid_state", 72'(state), 72'(S_PROC));
        proc_done = 1'b1;
        @(negedge clk);
        proc_done = 1'b0;
        k = 0;
        while (n_out - n0 < 2 && k < 100) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk("mid_two_out", 72'(n_out - n0), 72'd2);
        reset = 1'b0;
        #1;
        chk("mid_out_wr", 72'(out_wr), 72'd0);
        chk("mid_rst_state", 72'(state), 72'(S_FILL));
        chk("mid_rst_first", 72'(first_addr), 72'd0);
        chk("mid_rst_last", 72'(last_addr), 72'd0);
        chk("mid_rst_in_rdy", 72'(in_rdy), 72'd0);
        chk("mid_rst_drops", 72'(drop_count), 72'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rel_in_rdy", 72'(in_rdy), 72'd1);
        n0 = n_out;
        send_pkt(3, 64'hB000, 1'b1);
        chk("after_rst_first", 72'(first_addr), 72'd0);
        chk("after_rst_last", 72'(last_addr), 72'd2);
        pulse_done();
        drain_done(4'd3, 3, n0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cvt_pkt_buffer.md
# cvt_pkt_buffer

Parametrised convertible packet buffer for the NetFPGA user datapath, successor to the single-packet FIFO/SRAM used by the five-stage pipeline. It stores one packet at a time in a circular dual-port SRAM and hands the stored words to the processor for in-place read/modify through port A. When the processor signals completion, it drains the packet downstream. Over the previous generation it adds width/depth parameters, a circular pointer window with wrap-around, an oversize-packet drop path with a counter, and a bypass mode that skips processing.

## Interface
- DATA_WIDTH, 64, datapath word width
- CTRL_WIDTH, DATA_WIDTH/8, ctrl word width
- ADDR_WIDTH, 8, SRAM address width; DEPTH = 2^ADDR_WIDTH words
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- in_data / in_ctrl / in_wr  in  DATA_WIDTH / CTRL_WIDTH / 1  upstream stream
- in_rdy  out  1  buffer accepts a word this cycle
- out_data / out_ctrl / out_wr  out  DATA_WIDTH / CTRL_WIDTH / 1  downstream stream
- out_rdy  in  1  downstream accepts
- proc_addr  in  ADDR_WIDTH  absolute SRAM address, port A
- proc_wdata  in  DATA_WIDTH+CTRL_WIDTH  {ctrl,data} write word
- proc_we  in  1  write strobe, honoured only in PROC
- proc_rdata  out  DATA_WIDTH+CTRL_WIDTH  {ctrl,data} read word
- proc_done  in  1  one-cycle pulse: processing finished
- bypass  in  1  skip PROC for packets completing while high
- first_addr, last_addr  out  ADDR_WIDTH  current packet window
- pkt_ready  out  1  high in PROC
- state  out  2  FILL=0, PROC=1, DRAIN=2, DROP=3
- drop_count  out  16  saturating oversize-packet count

## Operation
- Packet framing: one or more header words (ctrl≠0), then body words (ctrl=0); the first ctrl≠0 word after a body word is the last word of the packet.
- FILL: in_rdy=1. Each word with in_wr=1 is written at wr_ptr; wr_ptr increments mod DEPTH. first_addr is the address of the packet's first word.
- End of packet in FILL: last_addr <= address of the last word. Go to DRAIN if bypass=1, else to PROC.
- Oversize: if a packet's word count would reach DEPTH before end of packet, discard that word, go to DROP, and increment drop_count (saturating at 0xFFFF).
- DROP: in_rdy=1. Discard words until end of packet, then go to FILL with wr_ptr=first_addr (buffer empty).
- PROC: in_rdy=0, pkt_ready=1, port A is owned by the processor. proc_rdata = mem[proc_addr] registered. proc_we writes proc_wdata at proc_addr. A proc_done pulse moves to DRAIN; proc_done is ignored in every other state.
- DRAIN: read first_addr..last_addr in order, with wrap, through a one-word output stage. out_wr = stage_valid & out_rdy, and the stage only advances when out_wr=1. After the last word is sent: first_addr <= last_addr+1, wr_ptr <= same, go to FILL.
- proc_we and proc_addr writes are ignored outside PROC. Port A reads stay live in all states.

## Timing
- Reset values: state=FILL, in_rdy=0, out_wr=0, out_data=0, out_ctrl=0, proc_rdata=0, first_addr=0, last_addr=0, wr_ptr=0, pkt_ready=0, drop_count=0. in_rdy becomes 1 at the first rising edge after reset deasserts.
- All outputs are registered.
- SRAM read latency is 1 cycle on both ports.
- Last word accepted at edge N: state/pkt_ready change at N+1, and in_rdy=0 from N+1.
- proc_done sampled high at edge M: state=DRAIN at M+1, first out_wr no earlier than M+2.
- Drain throughput is 1 word/cycle while out_rdy=1. With out_rdy low, out_data/out_ctrl hold and no word is lost or duplicated.
- Return to FILL: in_rdy=1 the cycle after the last out_wr.
- Simultaneous proc_we and proc_done: the write completes and the drained data includes it.
- Reset asserted mid-packet or mid-drain: immediate return to reset values. A partial packet is discarded and drop_count is not incremented.
- Wrap: pointer arithmetic is mod DEPTH. A packet of exactly DEPTH-1 words is legal. A packet of DEPTH words or more is dropped.

## Test plan
- ADDR_WIDTH=4: 1 header word + 4 body words + last word (6 words) -> PROC, first_addr=0, last_addr=5; proc_done -> 6 out_wr in order; then first_addr=6 in FILL.
- In PROC: write 0xDEAD at address 3, read it back (proc_rdata=0xDEAD one cycle later), pulse proc_done -> word 3 of the output equals 0xDEAD.
- After a 12-word packet (first_addr=0), a 7-word packet -> first_addr=12, last_addr=2 (wrapped); drained order = addresses 12..15, 0..2.
- 16-word packet at DEPTH=16 -> DROP, drop_count=1, nothing output; next 3-word packet -> PROC with first_addr at the pre-drop wr_ptr.
- bypass=1: a 4-word packet goes FILL->DRAIN with no proc_done; toggle out_rdy 1,0,0,1,1,... -> exactly 4 out_wr, data unchanged.
- Assert reset mid-drain (after 2 of 5 words) -> out_wr=0 immediately, state=FILL, pointers=0; in_rdy=1 one edge after release.
